// File: rtl/score_pkg.sv
// Shared types and seven-segment constants for the snake-game score display.
package score_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_ssd.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes blank the digit.
module bcd_to_ssd
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_n.sv
// N-digit BCD score keeper: counts good collisions, ends the round on a bad one,
// tracks the high score and blinks the display after a new high score.
module score_display_n
  import score_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int HOLD_CYCLES = 200,
  parameter int BLINK_DIV   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  goodCollButton,
  input  logic                  badCollButton,
  input  logic                  dispSel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   hiBcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  blinkToggle,
  output logic                  newHigh,
  output logic                  gameOver,
  output logic                  maxed
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t              state, state_next;
  logic                good_prev, bad_prev;
  logic                good_pulse, bad_pulse;
  logic [4*DIGITS-1:0] score, high_score, score_inc, sel_val;
  logic [7*DIGITS-1:0] dec_seg;
  logic [HW-1:0]       hold_cnt;
  logic [BW-1:0]       blink_cnt;
  logic                blink_tog, new_high, all_nines, hold_done;

  assign good_pulse = goodCollButton & ~good_prev;
  assign bad_pulse  = badCollButton & ~bad_prev;
  assign hold_done  = (state == OVER) && (hold_cnt == HOLD_LAST);

  always_comb begin
    logic       carry;
    logic [3:0] digit;
    carry     = 1'b1;
    digit     = 4'd0;
    score_inc = score;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = score[4*i +: 4];
      if (digit != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (digit == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = digit + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PLAY;
      good_prev <= 1'b0;
      bad_prev  <= 1'b0;
    end else begin
      state     <= state_next;
      good_prev <= goodCollButton;
      bad_prev  <= badCollButton;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY:    if (bad_pulse) state_next = OVER;
      OVER:    if (hold_done) state_next = PLAY;
      default: state_next = PLAY;
    endcase
  end

  // Digits are valid BCD with the MSD in the top bits, so a binary compare
  // orders scores the same way as a digit-by-digit compare from the MSD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score      <= '0;
      high_score <= '0;
      new_high   <= 1'b0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      blink_tog  <= 1'b0;
    end else if (state == PLAY) begin
      if (bad_pulse) begin
        if (score > high_score) begin
          high_score <= score;
          new_high   <= 1'b1;
        end
        hold_cnt  <= '0;
        blink_cnt <= '0;
        blink_tog <= 1'b0;
      end else if (good_pulse && !all_nines) begin
        score <= score_inc;
      end
    end else if (hold_done) begin
      score     <= '0;
      new_high  <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_tog <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
      if (new_high) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_tog <= ~blink_tog;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign sel_val = dispSel ? high_score : score;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_ssd u_dec (
      .bcd (sel_val[4*g +: 4]),
      .seg (dec_seg[7*g +: 7])
    );
  end

  assign seg         = ((state == OVER) && blink_tog) ? '0 : dec_seg;
  assign bcd         = score;
  assign hiBcd       = high_score;
  assign blinkToggle = blink_tog;
  assign newHigh     = new_high;
  assign gameOver    = (state == OVER);
  assign maxed       = all_nines;

endmodule

// File: tb/tb_score_display_n.sv
// Directed bench for score_display_n: a vector table plus hand-written round sequences.
module tb_score_display_n;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b0;
  logic        good = 1'b0, bad = 1'b0, sel = 1'b0;
  logic        good3 = 1'b0, bad3 = 1'b0, sel3 = 1'b0;
  logic [7:0]  bcd, hi_bcd;
  logic [13:0] seg;
  logic        blink_toggle, new_high, game_over, maxed;
  logic [11:0] bcd3, hi_bcd3;
  logic [20:0] seg3;
  logic        blink3, new_high3, game_over3, maxed3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  score_display_n #(.DIGITS(2), .HOLD_CYCLES(200), .BLINK_DIV(25)) dut (
    .clk(tb_clk), .rst(rst), .goodCollButton(good), .badCollButton(bad),
    .dispSel(sel), .bcd(bcd), .hiBcd(hi_bcd), .seg(seg),
    .blinkToggle(blink_toggle), .newHigh(new_high), .gameOver(game_over), .maxed(maxed)
  );

  score_display_n #(.DIGITS(3), .HOLD_CYCLES(200), .BLINK_DIV(25)) dut3 (
    .clk(tb_clk), .rst(rst), .goodCollButton(good3), .badCollButton(bad3),
    .dispSel(sel3), .bcd(bcd3), .hiBcd(hi_bcd3), .seg(seg3),
    .blinkToggle(blink3), .newHigh(new_high3), .gameOver(game_over3), .maxed(maxed3)
  );

  typedef struct {
    logic        good;
    logic        bad;
    logic        sel;
    logic [7:0]  exp_bcd;
    logic [13:0] exp_seg;
    logic        exp_over;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives inputs just after a falling edge, then samples on the next falling edge
  task automatic apply_stimulus(input logic g, input logic b, input logic s);
    good = g;
    bad  = b;
    sel  = s;
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  task automatic good_pulses(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      for (int j = 1; j < spacing; j++) apply_stimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    good = 1'b0; bad = 1'b0; sel = 1'b0;
    good3 = 1'b0; bad3 = 1'b0; sel3 = 1'b0;
    rst = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
  endtask

  task automatic wait_play(input int limit);
    int cycles;
    cycles = 0;
    while (game_over && cycles < limit) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      cycles++;
    end
    check_output("wait_play_timeout", 32'(game_over), 32'd0);
  endtask

  initial begin
    int over_err, blink_err, seg_err, bcd_err;
    logic exp_blink;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h01, 14'h1F86, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h01, 14'h1F86, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h01, 14'h1F86, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h02, 14'h1FDB, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h02, 14'h1FBF, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h03, 14'h1FCF, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h03, 14'h1FCF, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h03, 14'h1FCF, 1'b1};

    // Reset values while reset is held
    #12;
    check_output("reset_bcd", 32'(bcd), 32'h00);
    check_output("reset_hi", 32'(hi_bcd), 32'h00);
    check_output("reset_seg", 32'(seg), 32'h1FBF);
    check_output("reset_flags", {28'd0, blink_toggle, new_high, game_over, maxed}, 32'd0);
    check_output("reset_seg3", 32'(seg3), 32'hFDFBF);
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].good, vecs[i].bad, vecs[i].sel);
      check_output($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
      check_output($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].exp_seg));
      check_output($sformatf("vec%0d_over", i), 32'(game_over), 32'(vecs[i].exp_over));
    end
    check_output("vec_new_high", 32'(new_high), 32'd1);

    // Saturation: 100 pulses at 11-cycle spacing
    do_reset();
    good_pulses(10, 11);
    check_output("carry_10", 32'(bcd), 32'h10);
    good_pulses(89, 11);
    check_output("sat_99_bcd", 32'(bcd), 32'h99);
    check_output("sat_99_maxed", 32'(maxed), 32'd1);
    good_pulses(1, 11);
    check_output("sat_100_bcd", 32'(bcd), 32'h99);
    check_output("sat_100_maxed", 32'(maxed), 32'd1);

    // Round with a new high score: blink phase and blanking
    do_reset();
    good_pulses(12, 2);
    check_output("r1_bcd", 32'(bcd), 32'h12);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    bad = 1'b0;
    check_output("r1_hi", 32'(hi_bcd), 32'h12);
    check_output("r1_new_high", 32'(new_high), 32'd1);
    over_err = 0; blink_err = 0; seg_err = 0; bcd_err = 0;
    for (int k = 0; k < 200; k++) begin
      exp_blink = ((k / 25) % 2) == 1;
      if (game_over !== 1'b1) over_err++;
      if (blink_toggle !== exp_blink) blink_err++;
      if (seg !== (exp_blink ? 14'h0000 : 14'h035B)) seg_err++;
      if (bcd !== 8'h12) bcd_err++;
      apply_stimulus(k == 10, 1'b0, 1'b0);
    end
    check_output("r1_over_cycles", 32'(over_err), 32'd0);
    check_output("r1_blink", 32'(blink_err), 32'd0);
    check_output("r1_seg", 32'(seg_err), 32'd0);
    check_output("r1_frozen", 32'(bcd_err), 32'd0);
    check_output("r1_end_over", 32'(game_over), 32'd0);
    check_output("r1_end_bcd", 32'(bcd), 32'h00);
    check_output("r1_end_flags", {30'd0, new_high, blink_toggle}, 32'd0);
    check_output("r1_end_hi", 32'(hi_bcd), 32'h12);

    // Round without a new high score: steady display
    good_pulses(5, 2);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    bad = 1'b0;
    check_output("r2_hi", 32'(hi_bcd), 32'h12);
    check_output("r2_new_high", 32'(new_high), 32'd0);
    over_err = 0; blink_err = 0; seg_err = 0;
    for (int k = 0; k < 200; k++) begin
      if (game_over !== 1'b1) over_err++;
      if (blink_toggle !== 1'b0) blink_err++;
      if (seg !== 14'h1FED) seg_err++;
      apply_stimulus(1'b0, 1'b0, 1'b0);
    end
    check_output("r2_over_cycles", 32'(over_err), 32'd0);
    check_output("r2_blink", 32'(blink_err), 32'd0);
    check_output("r2_seg", 32'(seg_err), 32'd0);
    check_output("r2_end_over", 32'(game_over), 32'd0);

    // Good and bad on the same edge: bad wins
    good_pulses(7, 2);
    check_output("same_pre_bcd", 32'(bcd), 32'h07);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("same_bcd", 32'(bcd), 32'h07);
    check_output("same_over", 32'(game_over), 32'd1);
    check_output("same_new_high", 32'(new_high), 32'd0);
    wait_play(300);

    // Held button scores once
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("held_bcd", 32'(bcd), 32'h01);

    // Reset in the middle of OVER
    apply_stimulus(1'b0, 1'b1, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("mid_pre_over", 32'(game_over), 32'd1);
    rst = 1'b0;
    #1;
    check_output("mid_over", 32'(game_over), 32'd0);
    check_output("mid_hi", 32'(hi_bcd), 32'h00);
    check_output("mid_bcd", 32'(bcd), 32'h00);
    check_output("mid_seg", 32'(seg), 32'h1FBF);
    @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);

    // Three-digit instance: 109 pulses and high-score display
    for (int i = 0; i < 109; i++) begin
      good3 = 1'b1;
      @(negedge tb_clk);
      good3 = 1'b0;
      @(negedge tb_clk);
    end
    check_output("d3_bcd", 32'(bcd3), 32'h109);
    check_output("d3_seg_score", 32'(seg3), 32'h19FEF);
    sel3 = 1'b1;
    #1;
    check_output("d3_seg_hi_zero", 32'(seg3), 32'hFDFBF);
    sel3 = 1'b0;
    @(negedge tb_clk);
    bad3 = 1'b1;
    @(negedge tb_clk);
    bad3 = 1'b0;
    check_output("d3_over", 32'(game_over3), 32'd1);
    check_output("d3_hi", 32'(hi_bcd3), 32'h109);
    check_output("d3_new_high", 32'(new_high3), 32'd1);
    sel3 = 1'b1;
    #1;
    check_output("d3_seg_hi", 32'(seg3), 32'h19FEF);
    check_output("d3_maxed", 32'(maxed3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
